fifo_to_multilane_bridge: RTL and testbench

s and set rqst_err.
REQ-028 p2p_timeout SHALL be sampled only in FIN; changes during GAP have no effect.

Reset
REQ-029 Asynchronous rst_n=0 SHALL force state IDLE, buffer=0, ptr=0, counter=0, mode_lp=0, rqst_err=0; fifo_read, lane_start, lane_fin, busy = 0; lane_data = 0.
REQ-030 Reset mid-packet SHALL abandon the packet without lane_fin; the first cycle after release is IDLE.

Verification
REQ-031 LANES=4, FIFO holds 0x0_44332211, 0x0_88776655 (HS), rqst every ACTIVE cycle -> 2 reads, lane_start once, lane_data 0x44332211 then 0x88776655, lane_fin once, mode_lp=0.
REQ-032 LANES=1, one word 0x1_DDCCBBAA -> mode_lp=1, lane_data AA,BB,CC,DD over 4 rqsts, then lane_fin.
REQ-033 LANES=2, words HS 0x0_11111111 then LP 0x1_22222222 -> two packets, each with lane_start/lane_fin; second has mode_lp=1.
REQ-034 p2p_timeout=5, two back-to-back single-word packets -> exactly 5 cycles of GAP with fifo_read=0 between lane_fin and next read; p2p_timeout=0 -> no GAP.
REQ-035 lane_rqst pulsed in IDLE -> rqst_err=1 and stays 1; assert rst_n=0 mid-ACTIVE -> all outputs 0 asynchronously, no lane_fin.

---
 rtl/fifo_to_multilane_bridge.sv | 123 ++++++++++++
 tb/tb_fifo_to_multilane_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_to_multilane_bridge.sv
// Bridges a show-ahead 33-bit FIFO (LP flag + 4 bytes) onto LANES byte lanes in lockstep,
// framing each same-mode run of words as a packet with start/finish strobes and an idle gap.
module fifo_to_multilane_bridge #(
   parameter int LANES = 4,
   parameter int TMO_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [32:0]          fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_read,
   output logic                 mode_lp,
   output logic                 lane_start,
   output logic                 lane_fin,
   output logic [8*LANES-1:0]   lane_data,
   input  logic                 lane_rqst,
   input  logic [TMO_W-1:0]     p2p_timeout,
   output logic                 busy,
   output logic                 rqst_err
);

   typedef enum logic [2:0] {IDLE, START, ACTIVE, FIN, GAP} state_t;

   state_t            state_reg, state_next;
   logic [31:0]       buf_reg, buf_next;
   logic [1:0]        ptr_reg, ptr_next;
   logic [TMO_W-1:0]  cnt_reg, cnt_next;
   logic              mode_reg, mode_next;
   logic              err_reg, err_next;
   logic              last_slice;
   logic              same_mode;

   // A slice is the last one when it reaches the end of the 4-byte word.
   assign last_slice = (({1'b0, ptr_reg} + 3'(LANES)) >= 3'd4);
   assign same_mode  = (fifo_data[32] == mode_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         buf_reg   <= '0;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
         mode_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         buf_reg   <= buf_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         mode_reg  <= mode_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      buf_next   = buf_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      mode_next  = mode_reg;
      err_next   = err_reg | (lane_rqst && (state_reg != ACTIVE));
      fifo_read  = 1'b0;
      lane_start = 1'b0;
      lane_fin   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_read  = 1'b1;
               buf_next   = fifo_data[31:0];
               mode_next  = fifo_data[32];
               ptr_next   = 2'd0;
               state_next = START;
            end
         end
         START: begin
            lane_start = 1'b1;
            state_next = ACTIVE;
         end
         ACTIVE: begin
            if (lane_rqst) begin
               if (!last_slice) begin
                  ptr_next = ptr_reg + 2'(LANES);
               end else if (!fifo_empty && same_mode) begin
                  // Same-mode follow-on word extends the packet without a bubble.
                  fifo_read = 1'b1;
                  buf_next  = fifo_data[31:0];
                  ptr_next  = 2'd0;
               end else begin
                  state_next = FIN;
               end
            end
         end
         FIN: begin
            lane_fin   = 1'b1;
            cnt_next   = p2p_timeout;
            state_next = (p2p_timeout != '0) ? GAP : IDLE;
         end
         GAP: begin
            cnt_next = cnt_reg - TMO_W'(1);
            if (cnt_reg <= TMO_W'(1)) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [1:0] idx;
         assign idx = ptr_reg + 2'(gi);
         assign lane_data[8*gi +: 8] = (state_reg == ACTIVE) ? buf_reg[{idx, 3'b000} +: 8] : 8'd0;
      end
   endgenerate

   assign busy     = (state_reg != IDLE);
   assign mode_lp  = mode_reg;
   assign rqst_err = err_reg;

endmodule

// File: tb/tb_fifo_to_multilane_bridge.sv
// Scoreboard bench: three bridges (LANES 4, 1, 2) fed from queue-modelled FIFOs; expected
// start/slice/finish events are queued at load time and popped as the DUTs produce them.
module tb_fifo_to_multilane_bridge;

   localparam logic [1:0] EV_START = 2'd0;
   localparam logic [1:0] EV_DATA  = 2'd1;
   localparam logic [1:0] EV_FIN   = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] val;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] p2p_timeout;
   logic [32:0] fd [3];
   logic        fe [3];
   logic        rq [3];
   logic        fr [3];
   logic        mlp [3];
   logic        ls [3];
   logic        lf [3];
   logic        bsy [3];
   logic        rer [3];
   logic [31:0] ld0;
   logic [7:0]  ld1;
   logic [15:0] ld2;

   ev_t         ev_q [3][$];
   logic [32:0] fq [3][$];
   bit          act [3];
   bit          open_pk [3];
   bit          last_mode [3];
   int          words [3];
   int          reads [3];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   bit          gap_en = 0;
   bit          chg_tmo = 0;
   bit          fin_seen = 0;
   int          fin_cyc = 0;
   int          exp_gap = 0;

   always #5 clk = ~clk;

   fifo_to_multilane_bridge #(.LANES(4), .TMO_W(16)) u_l4 (
      .clk(clk), .rst_n(rst_n), .fifo_data(fd[0]), .fifo_empty(fe[0]), .fifo_read(fr[0]),
      .mode_lp(mlp[0]), .lane_start(ls[0]), .lane_fin(lf[0]), .lane_data(ld0),
      .lane_rqst(rq[0]), .p2p_timeout(p2p_timeout), .busy(bsy[0]), .rqst_err(rer[0]));

   fifo_to_multilane_bridge #(.LANES(1), .TMO_W(16)) u_l1 (
      .clk(clk), .rst_n(rst_n), .fifo_data(fd[1]), .fifo_empty(fe[1]), .fifo_read(fr[1]),
      .mode_lp(mlp[1]), .lane_start(ls[1]), .lane_fin(lf[1]), .lane_data(ld1),
      .lane_rqst(rq[1]), .p2p_timeout(p2p_timeout), .busy(bsy[1]), .rqst_err(rer[1]));

   fifo_to_multilane_bridge #(.LANES(2), .TMO_W(16)) u_l2 (
      .clk(clk), .rst_n(rst_n), .fifo_data(fd[2]), .fifo_empty(fe[2]), .fifo_read(fr[2]),
      .mode_lp(mlp[2]), .lane_start(ls[2]), .lane_fin(lf[2]), .lane_data(ld2),
      .lane_rqst(rq[2]), .p2p_timeout(p2p_timeout), .busy(bsy[2]), .rqst_err(rer[2]));

   function automatic int lanes_of(int i);
      return (i == 0) ? 4 : ((i == 1) ? 1 : 2);
   endfunction

   function automatic logic [31:0] ld_of(int i);
      if (i == 0) return ld0;
      if (i == 1) return {24'd0, ld1};
      return {16'd0, ld2};
   endfunction

   function automatic ev_t mk_ev(logic [1:0] k, logic [31:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      return e;
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %s: 0x%0h (cycle %0d)", tag, got, cyc);
      end
   endtask

   task automatic refresh(int i);
      fe[i] = (fq[i].size() == 0);
      fd[i] = (fq[i].size() > 0) ? fq[i][0] : 33'd0;
   endtask

   // Queue a word into FIFO i and derive the events a correct bridge must produce for it.
   task automatic load(int i, logic [32:0] w);
      int          l;
      logic [63:0] mask;
      logic [63:0] tmp;
      l    = lanes_of(i);
      mask = (64'd1 << (8 * l)) - 64'd1;
      if (open_pk[i] && (w[32] != last_mode[i])) ev_q[i].push_back(mk_ev(EV_FIN, 32'd0));
      if (!open_pk[i] || (w[32] != last_mode[i])) ev_q[i].push_back(mk_ev(EV_START, {31'd0, w[32]}));
      for (int j = 0; j < 4 / l; j++) begin
         tmp = ({32'd0, w[31:0]} >> (j * 8 * l)) & mask;
         ev_q[i].push_back(mk_ev(EV_DATA, tmp[31:0]));
      end
      open_pk[i]   = 1'b1;
      last_mode[i] = w[32];
      fq[i].push_back(w);
      words[i]++;
      refresh(i);
   endtask

   task automatic close_pk(int i);
      if (open_pk[i]) ev_q[i].push_back(mk_ev(EV_FIN, 32'd0));
      open_pk[i] = 1'b0;
   endtask

   task automatic pop_expect(int i, logic [1:0] kind, logic [31:0] val, string tag);
      ev_t e;
      string t;
      t = $sformatf("%s[L%0d]", tag, lanes_of(i));
      if (ev_q[i].size() == 0) begin
         check({t, "_unexpected"}, 64'd1, 64'd0);
      end else begin
         e = ev_q[i].pop_front();
         check(t, {30'd0, kind, val}, {30'd0, e.kind, e.val});
      end
   endtask

   task automatic cycle();
      bit pop [3];
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         pop[i] = 1'b0;
         if (ls[i]) begin
            pop_expect(i, EV_START, {31'd0, mlp[i]}, "start_mode");
            act[i] = 1'b1;
         end
         if (rq[i] && act[i]) pop_expect(i, EV_DATA, ld_of(i), "slice");
         if (lf[i]) begin
            pop_expect(i, EV_FIN, 32'd0, "fin");
            check($sformatf("busy_at_fin[L%0d]", lanes_of(i)), 64'(bsy[i]), 64'd1);
            if (i == 0) begin
               fin_seen = 1'b1;
               fin_cyc  = cyc;
            end
         end
         if (fr[i]) begin
            check($sformatf("read_nonempty[L%0d]", lanes_of(i)), 64'(fe[i]), 64'd0);
            if (i == 0 && gap_en && fin_seen) begin
               check("p2p_gap", 64'(cyc - fin_cyc - 1), 64'(exp_gap));
               fin_seen = 1'b0;
            end
            pop[i] = 1'b1;
            reads[i]++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         if (pop[i] && fq[i].size() > 0) void'(fq[i].pop_front());
         refresh(i);
         rq[i] = act[i] && (ev_q[i].size() > 0) && (ev_q[i][0].kind == EV_DATA);
         if (!rq[i]) act[i] = 1'b0;
      end
      if (chg_tmo && fin_seen) p2p_timeout = 16'd2;
   endtask

   task automatic run_to_idle(int max);
      int  n;
      bit  pending;
      n = 0;
      pending = 1'b1;
      while (pending && n < max) begin
         cycle();
         n++;
         pending = 1'b0;
         for (int i = 0; i < 3; i++)
            if (ev_q[i].size() > 0 || fq[i].size() > 0 || bsy[i]) pending = 1'b1;
      end
      check("drain_in_budget", 64'(n < max), 64'd1);
   endtask

   initial begin
      logic [2:0] exp_mode;
      rst_n       = 1'b0;
      p2p_timeout = 16'd3;
      for (int i = 0; i < 3; i++) begin
         fd[i] = 33'd0; fe[i] = 1'b1; rq[i] = 1'b0;
         act[i] = 0; open_pk[i] = 0; last_mode[i] = 0; words[i] = 0; reads[i] = 0;
      end
      #12;
      for (int i = 0; i < 3; i++)
         check($sformatf("reset_outputs[L%0d]", lanes_of(i)),
               {26'd0, fr[i], mlp[i], ls[i], lf[i], bsy[i], rer[i], ld_of(i)}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Concurrent basic packets on all three lane widths.
      load(0, 33'h0_44332211); load(0, 33'h0_88776655); close_pk(0);
      load(1, 33'h1_DDCCBBAA); close_pk(1);
      load(2, 33'h0_11111111); load(2, 33'h1_22222222); close_pk(2);
      run_to_idle(300);
      exp_mode = 3'b110;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("read_count[L%0d]", lanes_of(i)), 64'(reads[i]), 64'(words[i]));
         check($sformatf("mode_lp_final[L%0d]", lanes_of(i)), 64'(mlp[i]), 64'(exp_mode[i]));
         check($sformatf("rqst_err_clear[L%0d]", lanes_of(i)), 64'(rer[i]), 64'd0);
      end

      // Gap of 5 cycles; timeout is changed mid-gap and must not matter.
      p2p_timeout = 16'd5; gap_en = 1'b1; chg_tmo = 1'b1; fin_seen = 1'b0; exp_gap = 5;
      load(0, 33'h0_00000001); load(0, 33'h1_00000002); close_pk(0);
      run_to_idle(300);

      // Zero timeout: next read immediately follows finish; multi-word reload on narrow lanes.
      p2p_timeout = 16'd0; chg_tmo = 1'b0; fin_seen = 1'b0; exp_gap = 0;
      load(0, 33'h1_0A0B0C0D); load(0, 33'h0_01020304); close_pk(0);
      load(1, 33'h0_04030201); load(1, 33'h0_08070605); close_pk(1);
      load(2, 33'h1_D4C3B2A1); load(2, 33'h1_98877665); close_pk(2);
      run_to_idle(300);
      for (int i = 0; i < 3; i++)
         check($sformatf("read_count2[L%0d]", lanes_of(i)), 64'(reads[i]), 64'(words[i]));
      gap_en = 1'b0;

      // Stray request in IDLE sets a sticky error.
      rq[0] = 1'b1;
      cycle();
      check("rqst_err_set", 64'(rer[0]), 64'd1);
      repeat (3) cycle();
      check("rqst_err_sticky", 64'(rer[0]), 64'd1);
      check("rqst_err_other", 64'(rer[1]), 64'd0);

      // Asynchronous reset in the middle of an active packet.
      load(0, 33'h1_CAFEBABE); close_pk(0);
      cycle();
      cycle();
      #3;
      check("active_before_reset", 64'(ld0), 64'h0000_0000_CAFE_BABE);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {26'd0, fr[0], mlp[0], ls[0], lf[0], bsy[0], rer[0], ld0}, 64'd0);
      ev_q[0].delete(); fq[0].delete();
      act[0] = 1'b0; rq[0] = 1'b0; open_pk[0] = 1'b0;
      refresh(0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (8) cycle();
      check("idle_after_reset", 64'(bsy[0]), 64'd0);
      check("rqst_err_after_reset", 64'(rer[0]), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
